tile_ram: RTL and testbench



---
 rtl/tile_ram.sv | 189 ++++++++++++++++++
 tb/tb_tile_ram.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_ram.sv
// tile_ram: ROWS x COLS tile memory addressed as {row, col}, with a write
// port, a direct read port, and a raster scan engine that streams the whole
// tile out over valid/ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data write by coordinate; wr_err pulses a cycle after
//                         an out-of-range write (the write is dropped)
//   rd_en/rd_addr         direct read; rd_data/rd_valid/rd_err one cycle later
//   scan_start            begin raster scan (ignored while scan_busy)
//   scan_data/row/col     current beat, with scan_valid/scan_ready handshake
//   scan_last             beat is the last coordinate of the tile
//   scan_done             pulse in the cycle after the last beat is accepted
//   scan_busy             scan engine is fetching or presenting a beat
module tile_ram #(
  parameter int DATA_W = 8,
  parameter int ROW_AW = 3,
  parameter int COL_AW = 3,
  parameter int ROWS   = 8,
  parameter int COLS   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ROW_AW+COL_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_err,
  input  logic                     rd_en,
  input  logic [ROW_AW+COL_AW-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     rd_err,
  input  logic                     scan_start,
  output logic                     scan_busy,
  output logic [DATA_W-1:0]        scan_data,
  output logic [ROW_AW-1:0]        scan_row,
  output logic [COL_AW-1:0]        scan_col,
  output logic                     scan_valid,
  input  logic                     scan_ready,
  output logic                     scan_last,
  output logic                     scan_done
);

  localparam int AW    = ROW_AW + COL_AW;
  localparam int DEPTH = ROWS * COLS;
  localparam logic [ROW_AW:0]   ROWS_L   = (ROW_AW+1)'(ROWS);
  localparam logic [COL_AW:0]   COLS_L   = (COL_AW+1)'(COLS);
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(ROWS - 1);
  localparam logic [COL_AW-1:0] COL_LAST = COL_AW'(COLS - 1);
  localparam logic [AW-1:0]     COLS_AW  = AW'(COLS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a[AW-1:COL_AW]} < ROWS_L) && ({1'b0, a[COL_AW-1:0]} < COLS_L);
  endfunction

  // Rows are packed densely so non-power-of-two tiles waste no storage.
  function automatic logic [AW-1:0] addr_lin(input logic [ROW_AW-1:0] r,
                                             input logic [COL_AW-1:0] c);
    return AW'(r) * COLS_AW + AW'(c);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ROW_AW-1:0] scan_row_q, scan_row_d;
  logic [COL_AW-1:0] scan_col_q, scan_col_d;
  logic [DATA_W-1:0] scan_data_q, scan_data_d;
  logic              scan_done_q, scan_done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              wr_err_q, wr_err_d;

  logic              wr_ok, rd_ok, scan_fetch, beat_last;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [DATA_W-1:0] mem_rd;

  // One shared read port: the direct read wins, the scan read only happens
  // in FETCH when rd_en is low, so the two never collide.
  always_comb begin
    wr_ok      = addr_ok(wr_addr);
    rd_ok      = addr_ok(rd_addr);
    wr_idx     = addr_lin(wr_addr[AW-1:COL_AW], wr_addr[COL_AW-1:0]);
    scan_fetch = (state_q == S_FETCH) && !rd_en;
    rd_idx     = addr_lin(scan_row_q, scan_col_q);
    if (rd_en && rd_ok) begin
      rd_idx = addr_lin(rd_addr[AW-1:COL_AW], rd_addr[COL_AW-1:0]);
    end
    beat_last  = (scan_row_q == ROW_LAST) && (scan_col_q == COL_LAST);
  end

  // Sampled before the write lands at the same edge, giving read-first.
  assign mem_rd = mem[rd_idx];

  // Storage is intentionally outside the reset domain: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Datapath next values
  always_comb begin
    rd_data_d   = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_ok ? mem_rd : '0;
    end
    rd_valid_d  = rd_en;
    rd_err_d    = rd_en && !rd_ok;
    wr_err_d    = wr_en && !wr_ok;

    scan_row_d  = scan_row_q;
    scan_col_d  = scan_col_q;
    scan_data_d = scan_data_q;
    scan_done_d = 1'b0;
    if (state_q == S_IDLE && scan_start) begin
      scan_row_d = '0;
      scan_col_d = '0;
    end
    if (scan_fetch) begin
      scan_data_d = mem_rd;
    end
    if (state_q == S_VALID && scan_ready) begin
      if (beat_last) begin
        scan_done_d = 1'b1;
      end else if (scan_col_q == COL_LAST) begin
        scan_col_d = '0;
        scan_row_d = scan_row_q + 1'b1;
      end else begin
        scan_col_d = scan_col_q + 1'b1;
      end
    end
  end

  // Scan FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (scan_start) state_d = S_FETCH;
      S_FETCH: if (!rd_en) state_d = S_VALID;
      S_VALID: if (scan_ready) state_d = beat_last ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Scan FSM: outputs
  always_comb begin
    scan_valid = (state_q == S_VALID);
    scan_busy  = (state_q != S_IDLE);
    scan_last  = (state_q == S_VALID) && beat_last;
  end

  // State register and output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      scan_row_q  <= '0;
      scan_col_q  <= '0;
      scan_data_q <= '0;
      scan_done_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_row_q  <= scan_row_d;
      scan_col_q  <= scan_col_d;
      scan_data_q <= scan_data_d;
      scan_done_q <= scan_done_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign wr_err    = wr_err_q;
  assign scan_data = scan_data_q;
  assign scan_row  = scan_row_q;
  assign scan_col  = scan_col_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_tile_ram.sv
// Testbench for tile_ram: an 8x8 instance plus a 6-row instance sharing the
// same stimulus, checked against array models of the tile contents.
module tb_tile_ram;

  logic       clk, rst_n;
  logic       wr_en, rd_en, scan_start, scan_ready;
  logic [5:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  logic       wr_err, rd_valid, rd_err, scan_busy, scan_valid, scan_last, scan_done;
  logic [7:0] rd_data, scan_data;
  logic [2:0] scan_row, scan_col;

  logic       wr_err_6, rd_valid_6, rd_err_6, scan_busy_6, scan_valid_6, scan_last_6, scan_done_6;
  logic [7:0] rd_data_6, scan_data_6;
  logic [2:0] scan_row_6, scan_col_6;

  int total = 0;
  int bad   = 0;

  logic [7:0] model  [64];   // 8x8 tile, index row*8+col
  logic [7:0] model6 [64];   // 6-row tile, only rows 0..5 meaningful

  tile_ram dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_data(scan_data),
    .scan_row(scan_row), .scan_col(scan_col), .scan_valid(scan_valid),
    .scan_ready(scan_ready), .scan_last(scan_last), .scan_done(scan_done)
  );

  tile_ram #(.ROWS(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_6),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_6), .rd_valid(rd_valid_6), .rd_err(rd_err_6),
    .scan_start(scan_start), .scan_busy(scan_busy_6), .scan_data(scan_data_6),
    .scan_row(scan_row_6), .scan_col(scan_col_6), .scan_valid(scan_valid_6),
    .scan_ready(scan_ready), .scan_last(scan_last_6), .scan_done(scan_done_6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [5:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    model[a] = d;
    if (a[5:3] < 3'd6) model6[a] = d;
  endtask

  task automatic fill_pattern();
    for (int a = 0; a < 64; a++) write_word(6'(a), 8'((a / 8) * 8 + (a % 8)));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 0; rd_en = 0; scan_start = 0; scan_ready = 0;
    wr_addr = 0; rd_addr = 0; wr_data = 0;
    step(); step();
    total++;
    if ({rd_data, rd_valid, rd_err, wr_err, scan_data, scan_row, scan_col,
         scan_valid, scan_last, scan_done, scan_busy} !== 29'd0) begin
      bad++;
      $display("FAIL reset_outputs got rd=%h v=%b e=%b we=%b sd=%h r=%0d c=%0d sv=%b sl=%b dn=%b bz=%b req all 0",
               rd_data, rd_valid, rd_err, wr_err, scan_data, scan_row, scan_col,
               scan_valid, scan_last, scan_done, scan_busy);
    end
    rst_n = 1'b1;
    step();
    total++;
    if ({scan_busy, scan_valid, rd_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release got busy=%b valid=%b rdv=%b req 000", scan_busy, scan_valid, rd_valid);
    end
  endtask

  task automatic test_fill_readback();
    fill_pattern();
    for (int a = 0; a < 64; a++) begin
      rd_en = 1'b1; rd_addr = 6'(a);
      step();
      rd_en = 1'b0;
      total++;
      if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, model[a]}) begin
        bad++;
        $display("FAIL readback addr=%0d got v=%b e=%b d=%h req v=1 e=0 d=%h", a, rd_valid, rd_err, rd_data, model[a]);
      end
    end
  endtask

  task automatic test_read_during_write();
    write_word(6'd9, 8'h55);
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 8'hAA; rd_en = 1'b1; rd_addr = 6'd9;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    total++;
    if ({rd_valid, rd_data} !== {1'b1, 8'h55}) begin
      bad++;
      $display("FAIL rdw_old got v=%b d=%h req v=1 d=55", rd_valid, rd_data);
    end
    model[9] = 8'hAA; model6[9] = 8'hAA;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++;
    if ({rd_valid, rd_data} !== {1'b1, 8'hAA}) begin
      bad++;
      $display("FAIL rdw_new got v=%b d=%h req v=1 d=aa", rd_valid, rd_data);
    end
  endtask

  task automatic test_rows6_bounds();
    wr_en = 1'b1; wr_addr = {3'd6, 3'd0}; wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    model[48] = 8'hEE;
    total++;
    if ({wr_err_6, wr_err} !== 2'b10) begin
      bad++;
      $display("FAIL wr_err_pulse got err6=%b err8=%b req 1 0", wr_err_6, wr_err);
    end
    step();
    total++;
    if (wr_err_6 !== 1'b0) begin
      bad++;
      $display("FAIL wr_err_one_cycle got %b req 0", wr_err_6);
    end
    for (int a = 0; a < 48; a++) begin
      rd_en = 1'b1; rd_addr = 6'(a);
      step();
      rd_en = 1'b0;
      total++;
      if ({rd_valid_6, rd_err_6, rd_data_6} !== {1'b1, 1'b0, model6[a]}) begin
        bad++;
        $display("FAIL rows6_dump addr=%0d got v=%b e=%b d=%h req v=1 e=0 d=%h",
                 a, rd_valid_6, rd_err_6, rd_data_6, model6[a]);
      end
    end
    rd_en = 1'b1; rd_addr = {3'd7, 3'd3};
    step();
    rd_en = 1'b0;
    total++;
    if ({rd_valid_6, rd_err_6, rd_data_6} !== {1'b1, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL rows6_oob_read got v=%b e=%b d=%h req v=1 e=1 d=00", rd_valid_6, rd_err_6, rd_data_6);
    end
    total++;
    if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, model[59]}) begin
      bad++;
      $display("FAIL rows8_inrange_read got v=%b e=%b d=%h req v=1 e=0 d=%h", rd_valid, rd_err, rd_data, model[59]);
    end
  endtask

  task automatic test_random();
    logic [7:0] last_rd, last_rd6;
    last_rd = 8'h00; last_rd6 = 8'h00;
    for (int i = 0; i < 200; i++) begin
      logic       we, re;
      logic [5:0] wa, ra;
      logic [7:0] wd, exp_rd, exp_rd6;
      we = ($urandom_range(0, 1) == 1);
      re = (i == 0) || ($urandom_range(0, 1) == 1);
      wa = 6'($urandom_range(0, 63));
      ra = (i % 4 == 0) ? wa : 6'($urandom_range(0, 63));
      wd = 8'($urandom);
      exp_rd  = re ? model[ra] : last_rd;
      exp_rd6 = re ? ((ra[5:3] >= 3'd6) ? 8'h00 : model6[ra]) : last_rd6;
      wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      total++;
      if ({rd_valid, rd_err, rd_data, wr_err} !== {re, 1'b0, exp_rd, 1'b0}) begin
        bad++;
        $display("FAIL random8 i=%0d got v=%b e=%b d=%h we=%b req v=%b e=0 d=%h we=0",
                 i, rd_valid, rd_err, rd_data, wr_err, re, exp_rd);
      end
      total++;
      if ({rd_valid_6, rd_err_6, rd_data_6, wr_err_6} !==
          {re, re && (ra[5:3] >= 3'd6), exp_rd6, we && (wa[5:3] >= 3'd6)}) begin
        bad++;
        $display("FAIL random6 i=%0d got v=%b e=%b d=%h we=%b req v=%b e=%b d=%h we=%b",
                 i, rd_valid_6, rd_err_6, rd_data_6, wr_err_6, re, re && (ra[5:3] >= 3'd6),
                 exp_rd6, we && (wa[5:3] >= 3'd6));
      end
      last_rd = exp_rd; last_rd6 = exp_rd6;
      if (we) begin
        model[wa] = wd;
        if (wa[5:3] < 3'd6) model6[wa] = wd;
      end
    end
  endtask

  task automatic test_scan_full();
    fill_pattern();
    scan_ready = 1'b1; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int c = 1; c <= 131; c++) begin
      logic ev, e_busy, e_last, e_done;
      int   k;
      ev     = (c >= 2) && (c <= 128) && (c % 2 == 0);
      e_busy = (c <= 128);
      e_last = (c == 128);
      e_done = (c == 129);
      k      = (c - 2) / 2;
      total++;
      if ({scan_busy, scan_valid, scan_last, scan_done} !== {e_busy, ev, e_last, e_done}) begin
        bad++;
        $display("FAIL scan_ctrl cycle=%0d got busy=%b valid=%b last=%b done=%b req %b %b %b %b",
                 c, scan_busy, scan_valid, scan_last, scan_done, e_busy, ev, e_last, e_done);
      end
      if (ev) begin
        total++;
        if ({scan_row, scan_col, scan_data} !== {3'(k / 8), 3'(k % 8), model[k]}) begin
          bad++;
          $display("FAIL scan_beat k=%0d got r=%0d c=%0d d=%h req r=%0d c=%0d d=%h",
                   k, scan_row, scan_col, scan_data, k / 8, k % 8, model[k]);
        end
      end
      step();
    end
  endtask

  task automatic test_stall_and_priority();
    int         k, budget;
    logic       stalled, injected, done;
    logic [7:0] cap_d;
    logic [2:0] cap_r, cap_c;
    k = 0; budget = 0; stalled = 0; injected = 0; done = 0;
    scan_ready = 1'b1; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    while (!done && budget < 400) begin
      budget++;
      if (scan_done) begin
        done = 1'b1;
      end else if (scan_valid) begin
        total++;
        if (k > 63 || {scan_row, scan_col, scan_data, scan_last} !==
                      {3'(k / 8), 3'(k % 8), model[k[5:0]], (k == 63)}) begin
          bad++;
          $display("FAIL stall_beat k=%0d got r=%0d c=%0d d=%h l=%b", k, scan_row, scan_col, scan_data, scan_last);
        end
        if (k == 10 && !stalled) begin
          stalled = 1'b1;
          scan_ready = 1'b0;
          cap_d = scan_data; cap_r = scan_row; cap_c = scan_col;
          for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({scan_valid, scan_row, scan_col, scan_data} !== {1'b1, 3'd1, 3'd2, model[10]} ||
                {cap_r, cap_c, cap_d} !== {scan_row, scan_col, scan_data}) begin
              bad++;
              $display("FAIL stall_hold i=%0d got v=%b r=%0d c=%0d d=%h req v=1 r=1 c=2 d=%h",
                       i, scan_valid, scan_row, scan_col, scan_data, model[10]);
            end
          end
          scan_ready = 1'b1;
        end
        step();
        k++;
      end else if (scan_busy && k == 15 && !injected) begin
        injected = 1'b1;
        rd_en = 1'b1; rd_addr = {3'd2, 3'd3};
        step();
        rd_en = 1'b0;
        total++;
        if ({rd_valid, rd_err, rd_data, scan_valid, scan_busy} !== {1'b1, 1'b0, model[19], 1'b0, 1'b1}) begin
          bad++;
          $display("FAIL fetch_priority got rv=%b re=%b rd=%h sv=%b bz=%b req 1 0 %h 0 1",
                   rd_valid, rd_err, rd_data, scan_valid, scan_busy, model[19]);
        end
      end else begin
        step();
      end
    end
    total++;
    if (!done || k != 64 || !stalled || !injected) begin
      bad++;
      $display("FAIL stall_complete got done=%b beats=%0d stalled=%b injected=%b req 1 64 1 1",
               done, k, stalled, injected);
    end
  endtask

  task automatic test_reset_mid_scan();
    int k, budget;
    k = 0; budget = 0;
    scan_ready = 1'b1; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    while (!(scan_valid && k == 20) && budget < 200) begin
      budget++;
      if (scan_valid) k++;
      step();
    end
    total++;
    if (!(scan_valid && k == 20)) begin
      bad++;
      $display("FAIL reach_beat20 got valid=%b beats=%0d req 1 20", scan_valid, k);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rd_data, rd_valid, rd_err, wr_err, scan_data, scan_row, scan_col,
         scan_valid, scan_last, scan_done, scan_busy} !== 29'd0) begin
      bad++;
      $display("FAIL async_reset got sd=%h r=%0d c=%0d sv=%b bz=%b req all 0",
               scan_data, scan_row, scan_col, scan_valid, scan_busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) #2 rst_n = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({scan_done, scan_busy, scan_valid} !== 3'b000) begin
        bad++;
        $display("FAIL post_reset_idle i=%0d got done=%b busy=%b valid=%b req 000", i, scan_done, scan_busy, scan_valid);
      end
    end
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      step();
      total++;
      if ({scan_valid, scan_row, scan_col, scan_data} !== {1'b1, 3'd0, 3'(b), model[b]}) begin
        bad++;
        $display("FAIL restart_beat b=%0d got v=%b r=%0d c=%0d d=%h req v=1 r=0 c=%0d d=%h",
                 b, scan_valid, scan_row, scan_col, scan_data, b, model[b]);
      end
      step();
    end
    budget = 0;
    while (scan_busy && budget < 200) begin
      budget++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_fill_readback();
    test_read_during_write();
    test_rows6_bounds();
    test_random();
    test_scan_full();
    test_stall_and_priority();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
